// File: rtl/sram_a_reader.sv
// sram_a_reader: burst read initiator for activation SRAM bank A.
// Issues credit-limited single-byte reads and streams the returned bytes through a 2-entry FIFO.
module sram_a_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   beat_cnt;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              inflight;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              pop;
    logic [1:0]        slots_used;

    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = fifo_mem[rd_ptr];
    assign m_last  = m_valid && (beat_cnt == (ADDR_W+1)'(1));
    assign pop     = m_valid && m_ready;

    // A read may issue only if its data is guaranteed a FIFO slot, counting the slot this cycle's pop frees.
    assign slots_used = fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    assign sram_ce    = (state == RUN) && (issue_cnt != '0) && (slots_used < 2'd2);
    assign sram_addr  = sram_ce ? next_addr : last_addr;
    assign sram_we    = 1'b0;
    assign sram_din   = '0;
    assign busy       = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            beat_cnt    <= '0;
            next_addr   <= '0;
            last_addr   <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
            done        <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= sram_ce;
            if (sram_ce) begin
                last_addr <= next_addr;
                next_addr <= next_addr + ADDR_W'(1);
                issue_cnt <= issue_cnt - (ADDR_W+1)'(1);
            end
            if (inflight) begin
                fifo_mem[wr_ptr] <= sram_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                beat_cnt <= beat_cnt - (ADDR_W+1)'(1);
            end
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RUN;
                            next_addr <= base_addr;
                            issue_cnt <= length;
                            beat_cnt  <= length;
                        end
                    end
                end
                RUN: begin
                    if (pop && (beat_cnt == (ADDR_W+1)'(1))) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
